// File: rtl/apb_pkg.sv
// rtl/apb_pkg.sv - shared state encoding, PPROT bit positions and select-width helper
package apb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2,
        ST_DECERR = 2'd3
    } apb_state_t;

    localparam int PPROT_PRIV   = 0;
    localparam int PPROT_NONSEC = 1;
    localparam int PPROT_INSTR  = 2;

    // Width of the slave index field: at least one bit even for a single slave
    function automatic int sw_width(input int num_slaves);
        return (num_slaves > 1) ? $clog2(num_slaves) : 1;
    endfunction

endpackage

// File: rtl/apb_addr_decoder.sv
// rtl/apb_addr_decoder.sv - address to one-hot PSEL decode with out-of-range flag
module apb_addr_decoder
    import apb_pkg::*;
#(
    parameter int ADDR_WIDTH   = 32,
    parameter int NUM_SLAVES   = 4,
    parameter int SLV_ADDR_LSB = 28
) (
    input  logic [ADDR_WIDTH-1:0] addr,
    output logic [NUM_SLAVES-1:0] sel,
    output logic                  out_of_range
);

    localparam int SW = sw_width(NUM_SLAVES);

    logic [SW-1:0] idx;
    logic          unused_addr_bits;

    assign idx              = addr[SLV_ADDR_LSB +: SW];
    assign unused_addr_bits = ^addr;

    // An index past the last slave selects nothing so the bus stays quiet
    always_comb begin
        sel          = '0;
        out_of_range = (int'(idx) >= NUM_SLAVES);
        for (int k = 0; k < NUM_SLAVES; k++) begin
            if (int'(idx) == k) begin
                sel[k] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/apb4_master_mux.sv
// rtl/apb4_master_mux.sv - valid/ready to APB4 master with slave decode, read mux and timeout
module apb4_master_mux
    import apb_pkg::*;
#(
    parameter int ADDR_WIDTH   = 32,
    parameter int DATA_WIDTH   = 32,
    parameter int NUM_SLAVES   = 4,
    parameter int SLV_ADDR_LSB = 28,
    parameter int TIMEOUT      = 16
) (
    input  logic                             i_clk,
    input  logic                             i_reset_n,
    input  logic                             i_valid,
    output logic                             o_ready,
    input  logic [ADDR_WIDTH-1:0]            i_addr,
    input  logic                             i_write,
    input  logic [DATA_WIDTH-1:0]            i_wdata,
    input  logic [DATA_WIDTH/8-1:0]          i_strb,
    input  logic [2:0]                       i_prot,
    output logic                             o_done,
    output logic [DATA_WIDTH-1:0]            o_rdata,
    output logic                             o_slverr,
    output logic                             o_timeout,
    output logic [ADDR_WIDTH-1:0]            PADDR,
    output logic                             PWRITE,
    output logic [DATA_WIDTH-1:0]            PWDATA,
    output logic [DATA_WIDTH/8-1:0]          PSTRB,
    output logic [2:0]                       PPROT,
    output logic [NUM_SLAVES-1:0]            PSEL,
    output logic                             PENABLE,
    input  logic [NUM_SLAVES*DATA_WIDTH-1:0] PRDATA,
    input  logic [NUM_SLAVES-1:0]            PREADY,
    input  logic [NUM_SLAVES-1:0]            PSLVERR
);

    localparam int CNT_WIDTH = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    apb_state_t              state, next_state;
    logic [NUM_SLAVES-1:0]   dec_sel;
    logic                    dec_oor;
    logic [CNT_WIDTH-1:0]    tmo_cnt;
    logic                    pready_sel, pslverr_sel, tmo_fire;
    logic                    accept, complete, abort;
    logic [DATA_WIDTH-1:0]   prdata_sel;

    apb_addr_decoder #(
        .ADDR_WIDTH   (ADDR_WIDTH),
        .NUM_SLAVES   (NUM_SLAVES),
        .SLV_ADDR_LSB (SLV_ADDR_LSB)
    ) u_decoder (
        .addr         (i_addr),
        .sel          (dec_sel),
        .out_of_range (dec_oor)
    );

    // PSEL is one-hot (or zero), so masking and OR-reducing is the response mux
    always_comb begin
        prdata_sel  = '0;
        pready_sel  = |(PREADY & PSEL);
        pslverr_sel = |(PSLVERR & PSEL);
        for (int k = 0; k < NUM_SLAVES; k++) begin
            if (PSEL[k]) begin
                prdata_sel = prdata_sel | PRDATA[k*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    assign tmo_fire = (TIMEOUT > 0) && (state == ST_ACCESS) && !pready_sel && (tmo_cnt == CNT_LAST);

    // State register
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next state and handshake; a completing or aborting ACCESS may take a new request directly
    always_comb begin
        next_state = state;
        o_ready    = 1'b0;
        complete   = 1'b0;
        abort      = 1'b0;
        case (state)
            ST_IDLE:   o_ready = 1'b1;
            ST_SETUP:  next_state = ST_ACCESS;
            ST_ACCESS: begin
                complete = pready_sel;
                abort    = tmo_fire;
                o_ready  = pready_sel | tmo_fire;
            end
            ST_DECERR: o_ready = 1'b1;
            default:   next_state = ST_IDLE;
        endcase
        accept = i_valid && o_ready;
        if (o_ready) begin
            next_state = accept ? (dec_oor ? ST_DECERR : ST_SETUP) : ST_IDLE;
        end
    end

    // Bus registers, completion status and the ACCESS cycle counter
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            PADDR     <= '0;
            PWRITE    <= 1'b0;
            PWDATA    <= '0;
            PSTRB     <= '0;
            PPROT     <= '0;
            PSEL      <= '0;
            PENABLE   <= 1'b0;
            o_done    <= 1'b0;
            o_rdata   <= '0;
            o_slverr  <= 1'b0;
            o_timeout <= 1'b0;
            tmo_cnt   <= '0;
        end else begin
            o_done <= 1'b0;
            if (complete) begin
                o_done    <= 1'b1;
                o_slverr  <= pslverr_sel;
                o_timeout <= 1'b0;
                if (!PWRITE) begin
                    o_rdata <= prdata_sel;
                end
            end else if (abort) begin
                o_done    <= 1'b1;
                o_slverr  <= 1'b1;
                o_timeout <= 1'b1;
            end else if (state == ST_DECERR) begin
                o_done    <= 1'b1;
                o_slverr  <= 1'b1;
                o_timeout <= 1'b0;
            end

            if (accept) begin
                PADDR   <= i_addr;
                PWRITE  <= i_write;
                PWDATA  <= i_wdata;
                PSTRB   <= i_write ? i_strb : '0;
                PPROT   <= i_prot;
                PSEL    <= dec_sel;
                PENABLE <= 1'b0;
            end else if (state == ST_SETUP) begin
                PENABLE <= 1'b1;
            end else if (o_ready) begin
                PSEL    <= '0;
                PENABLE <= 1'b0;
            end

            if (state == ST_SETUP) begin
                tmo_cnt <= '0;
            end else if ((state == ST_ACCESS) && !pready_sel && !tmo_fire) begin
                tmo_cnt <= tmo_cnt + CNT_WIDTH'(1);
            end
        end
    end

endmodule

// File: tb/tb_apb4_master_mux.sv
// tb/tb_apb4_master_mux.sv - directed self-checking bench for apb4_master_mux
module tb_apb4_master_mux;

    logic        clk = 1'b0;
    logic        i_reset_n;
    logic        i_valid;
    logic        o_ready;
    logic [31:0] i_addr;
    logic        i_write;
    logic [31:0] i_wdata;
    logic [3:0]  i_strb;
    logic [2:0]  i_prot;
    logic        o_done;
    logic [31:0] o_rdata;
    logic        o_slverr;
    logic        o_timeout;
    logic [31:0] PADDR;
    logic        PWRITE;
    logic [31:0] PWDATA;
    logic [3:0]  PSTRB;
    logic [2:0]  PPROT;
    logic [2:0]  PSEL;
    logic        PENABLE;
    logic [95:0] PRDATA;
    logic [2:0]  PREADY;
    logic [2:0]  PSLVERR;

    int          tests = 0;
    int          fails = 0;

    // Slave model configuration: wait states, stuck-not-ready, read data and error per slave
    int          wait_cfg  [3];
    logic [2:0]  stuck_cfg;
    logic [31:0] rdata_cfg [3];
    int          wcnt = 0;

    always #5 clk = ~clk;

    apb4_master_mux #(
        .ADDR_WIDTH   (32),
        .DATA_WIDTH   (32),
        .NUM_SLAVES   (3),
        .SLV_ADDR_LSB (28),
        .TIMEOUT      (16)
    ) dut (
        .i_clk     (clk),
        .i_reset_n (i_reset_n),
        .i_valid   (i_valid),
        .o_ready   (o_ready),
        .i_addr    (i_addr),
        .i_write   (i_write),
        .i_wdata   (i_wdata),
        .i_strb    (i_strb),
        .i_prot    (i_prot),
        .o_done    (o_done),
        .o_rdata   (o_rdata),
        .o_slverr  (o_slverr),
        .o_timeout (o_timeout),
        .PADDR     (PADDR),
        .PWRITE    (PWRITE),
        .PWDATA    (PWDATA),
        .PSTRB     (PSTRB),
        .PPROT     (PPROT),
        .PSEL      (PSEL),
        .PENABLE   (PENABLE),
        .PRDATA    (PRDATA),
        .PREADY    (PREADY),
        .PSLVERR   (PSLVERR)
    );

    assign PRDATA = {rdata_cfg[2], rdata_cfg[1], rdata_cfg[0]};

    // Counts ACCESS cycles of the current transfer that have not seen PREADY
    always @(posedge clk) begin
        if (PENABLE && ((PREADY & PSEL) == 3'b000)) wcnt <= wcnt + 1;
        else wcnt <= 0;
    end

    always_comb begin
        PREADY = 3'b000;
        for (int k = 0; k < 3; k++) begin
            PREADY[k] = PSEL[k] & PENABLE & ~stuck_cfg[k] & (wcnt >= wait_cfg[k]);
        end
    end

    task automatic issue(input logic [31:0] a, input logic w, input logic [31:0] d,
                         input logic [3:0] s, input logic [2:0] p);
        i_addr = a; i_write = w; i_wdata = d; i_strb = s; i_prot = p;
        i_valid = 1'b1;
        @(negedge clk);
        i_valid = 1'b0;
    endtask

    task automatic observe(input int ncyc, output int psel_c, output int pen_c, output int done_at,
                           output int done_n, output int strb_c);
        psel_c = 0; pen_c = 0; done_at = -1; done_n = 0; strb_c = 0;
        for (int c = 1; c <= ncyc; c++) begin
            if (PSEL != 3'b000) psel_c++;
            if (PENABLE) pen_c++;
            if (PSTRB != 4'h0) strb_c++;
            if (o_done) begin
                done_n++;
                if (done_at < 0) done_at = c;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        i_reset_n = 1'b0;
        repeat (2) @(negedge clk);
        tests++; if (PSEL !== 3'b000) begin fails++; $display("FAIL reset_psel got %b want 000", PSEL); end
        tests++; if (PENABLE !== 1'b0) begin fails++; $display("FAIL reset_penable got %b want 0", PENABLE); end
        tests++; if (o_done !== 1'b0 || o_slverr !== 1'b0 || o_timeout !== 1'b0) begin fails++; $display("FAIL reset_status got %b%b%b want 000", o_done, o_slverr, o_timeout); end
        tests++; if (o_rdata !== 32'h0 || PADDR !== 32'h0) begin fails++; $display("FAIL reset_regs got rdata %h paddr %h want 0", o_rdata, PADDR); end
        tests++; if (o_ready !== 1'b1) begin fails++; $display("FAIL reset_ready got %b want 1", o_ready); end
        i_reset_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_write();
        int psel_c, pen_c, done_at, done_n, strb_c;
        wait_cfg[1] = 0;
        tests++; if (o_ready !== 1'b1) begin fails++; $display("FAIL write_ready_idle got %b want 1", o_ready); end
        issue(32'h1000_0004, 1'b1, 32'hDEAD_BEEF, 4'b1111, 3'b011);
        tests++; if (PSEL !== 3'b010 || PENABLE !== 1'b0) begin fails++; $display("FAIL write_setup got psel %b pen %b want 010 0", PSEL, PENABLE); end
        tests++; if (PADDR !== 32'h1000_0004 || PWDATA !== 32'hDEAD_BEEF || PWRITE !== 1'b1) begin fails++; $display("FAIL write_bus got %h %h %b want 10000004 deadbeef 1", PADDR, PWDATA, PWRITE); end
        tests++; if (PSTRB !== 4'b1111 || PPROT !== 3'b011) begin fails++; $display("FAIL write_strb_prot got %b %b want 1111 011", PSTRB, PPROT); end
        observe(8, psel_c, pen_c, done_at, done_n, strb_c);
        tests++; if (psel_c !== 2) begin fails++; $display("FAIL write_psel_cycles got %0d want 2", psel_c); end
        tests++; if (done_at !== 3 || done_n !== 1) begin fails++; $display("FAIL write_done got at %0d count %0d want 3 1", done_at, done_n); end
        tests++; if (o_slverr !== 1'b0 || o_timeout !== 1'b0) begin fails++; $display("FAIL write_err got %b %b want 0 0", o_slverr, o_timeout); end
    endtask

    task automatic test_read_wait();
        int psel_c, pen_c, done_at, done_n, strb_c;
        wait_cfg[2] = 3; rdata_cfg[2] = 32'h1234_5678;
        issue(32'h2000_0000, 1'b0, 32'hFFFF_FFFF, 4'b1111, 3'b000);
        observe(12, psel_c, pen_c, done_at, done_n, strb_c);
        tests++; if (pen_c !== 4) begin fails++; $display("FAIL read_penable_cycles got %0d want 4", pen_c); end
        tests++; if (done_at !== 6 || done_n !== 1) begin fails++; $display("FAIL read_done got at %0d count %0d want 6 1", done_at, done_n); end
        tests++; if (strb_c !== 0) begin fails++; $display("FAIL read_pstrb got %0d nonzero cycles want 0", strb_c); end
        tests++; if (o_rdata !== 32'h1234_5678) begin fails++; $display("FAIL read_rdata got %h want 12345678", o_rdata); end
    endtask

    task automatic test_slverr();
        int psel_c, pen_c, done_at, done_n, strb_c;
        wait_cfg[0] = 0; PSLVERR = 3'b001;
        issue(32'h0000_0100, 1'b1, 32'h0000_00AA, 4'b0001, 3'b000);
        observe(6, psel_c, pen_c, done_at, done_n, strb_c);
        tests++; if (o_slverr !== 1'b1 || o_timeout !== 1'b0) begin fails++; $display("FAIL slverr_status got %b %b want 1 0", o_slverr, o_timeout); end
        tests++; if (o_rdata !== 32'h1234_5678) begin fails++; $display("FAIL slverr_rdata_hold got %h want 12345678", o_rdata); end
        PSLVERR = 3'b000;
    endtask

    task automatic test_back_to_back();
        int d1, d2, extra, gaps, b_setup;
        logic pend;
        wait_cfg[0] = 1; wait_cfg[1] = 1; rdata_cfg[1] = 32'hCAFE_F00D;
        i_addr = 32'h0000_0010; i_write = 1'b1; i_wdata = 32'h5555_AAAA; i_strb = 4'b0011; i_prot = 3'b001;
        i_valid = 1'b1;
        @(negedge clk);
        i_addr = 32'h1000_0020; i_write = 1'b0; i_wdata = 32'h0; i_strb = 4'b0000; i_prot = 3'b100;
        d1 = -1; d2 = -1; extra = 0; gaps = 0; b_setup = -1; pend = 1'b0;
        for (int c = 1; c <= 14; c++) begin
            if (pend) i_valid = 1'b0;
            if (o_done) begin
                if (d1 < 0) d1 = c;
                else if (d2 < 0) d2 = c;
                else extra++;
            end
            if (c <= 6 && PSEL == 3'b000) gaps++;
            if (c > 1 && PSEL == 3'b010 && !PENABLE && b_setup < 0) b_setup = c;
            pend = i_valid && o_ready;
            @(negedge clk);
        end
        i_valid = 1'b0;
        tests++; if (b_setup !== 4) begin fails++; $display("FAIL b2b_second_setup got cycle %0d want 4", b_setup); end
        tests++; if (gaps !== 0) begin fails++; $display("FAIL b2b_idle_gap got %0d idle cycles want 0", gaps); end
        tests++; if (d1 !== 4 || d2 !== 7 || extra !== 0) begin fails++; $display("FAIL b2b_done got %0d %0d extra %0d want 4 7 0", d1, d2, extra); end
        tests++; if (o_rdata !== 32'hCAFE_F00D) begin fails++; $display("FAIL b2b_rdata got %h want cafef00d", o_rdata); end
    endtask

    task automatic test_timeout();
        int psel_c, pen_c, done_at, done_n, strb_c;
        stuck_cfg = 3'b100;
        issue(32'h2000_0008, 1'b0, 32'h0, 4'b0000, 3'b000);
        observe(25, psel_c, pen_c, done_at, done_n, strb_c);
        tests++; if (pen_c !== 16) begin fails++; $display("FAIL timeout_access_cycles got %0d want 16", pen_c); end
        tests++; if (psel_c !== 17) begin fails++; $display("FAIL timeout_psel_cycles got %0d want 17", psel_c); end
        tests++; if (done_at !== 18 || done_n !== 1) begin fails++; $display("FAIL timeout_done got at %0d count %0d want 18 1", done_at, done_n); end
        tests++; if (o_slverr !== 1'b1 || o_timeout !== 1'b1) begin fails++; $display("FAIL timeout_status got %b %b want 1 1", o_slverr, o_timeout); end
        tests++; if (o_rdata !== 32'hCAFE_F00D) begin fails++; $display("FAIL timeout_rdata_hold got %h want cafef00d", o_rdata); end
        stuck_cfg = 3'b000;
    endtask

    task automatic test_decode_error();
        int psel_c, pen_c, done_at, done_n, strb_c;
        issue(32'h3000_0000, 1'b1, 32'h1111_2222, 4'b1111, 3'b000);
        tests++; if (o_ready !== 1'b1) begin fails++; $display("FAIL decerr_ready got %b want 1", o_ready); end
        observe(6, psel_c, pen_c, done_at, done_n, strb_c);
        tests++; if (psel_c !== 0 || pen_c !== 0) begin fails++; $display("FAIL decerr_bus got psel %0d pen %0d cycles want 0 0", psel_c, pen_c); end
        tests++; if (done_at !== 2 || done_n !== 1) begin fails++; $display("FAIL decerr_done got at %0d count %0d want 2 1", done_at, done_n); end
        tests++; if (o_slverr !== 1'b1 || o_timeout !== 1'b0) begin fails++; $display("FAIL decerr_status got %b %b want 1 0", o_slverr, o_timeout); end
    endtask

    task automatic test_reset_mid();
        int psel_c, pen_c, done_at, done_n, strb_c;
        stuck_cfg = 3'b010;
        issue(32'h1000_0040, 1'b0, 32'h0, 4'b0000, 3'b000);
        @(negedge clk);
        tests++; if (PENABLE !== 1'b1 || PSEL !== 3'b010) begin fails++; $display("FAIL rstmid_access got pen %b psel %b want 1 010", PENABLE, PSEL); end
        i_reset_n = 1'b0;
        @(negedge clk);
        tests++; if (PSEL !== 3'b000 || PENABLE !== 1'b0) begin fails++; $display("FAIL rstmid_bus got psel %b pen %b want 000 0", PSEL, PENABLE); end
        tests++; if (o_done !== 1'b0 || o_slverr !== 1'b0) begin fails++; $display("FAIL rstmid_status got done %b err %b want 0 0", o_done, o_slverr); end
        i_reset_n = 1'b1;
        observe(20, psel_c, pen_c, done_at, done_n, strb_c);
        tests++; if (done_n !== 0 || psel_c !== 0) begin fails++; $display("FAIL rstmid_after got done %0d psel %0d cycles want 0 0", done_n, psel_c); end
        stuck_cfg = 3'b000;
    endtask

    initial begin
        i_reset_n = 1'b0; i_valid = 1'b0; i_addr = '0; i_write = 1'b0;
        i_wdata = '0; i_strb = '0; i_prot = '0; PSLVERR = 3'b000; stuck_cfg = 3'b000;
        for (int k = 0; k < 3; k++) begin
            wait_cfg[k] = 0;
            rdata_cfg[k] = 32'h0;
        end
        @(negedge clk);
        test_reset();
        test_write();
        test_read_wait();
        test_slverr();
        test_back_to_back();
        test_timeout();
        test_decode_error();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
